ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the PC loaded at reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-006 SHALL have port imem_addr  output  32  fetch address; equals pc while imem_req_valid=1.
REQ-007 SHALL have port imem_rsp_valid  input  1  fetch data returned this cycle.
REQ-008 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-009 SHALL have port inst_valid  output  1  instruction presented to the decode stage.
REQ-010 SHALL have port inst_ready  input  1  decode stage consumes the instruction.
REQ-011 SHALL have port instruction  output  32  held instruction word, stable while inst_valid=1.
REQ-012 SHALL have port pc  output  32  address of the fetch in flight or of the held instruction.
REQ-013 SHALL have port redirect_valid  input  1  jump/branch taken (jal/jalr path).
REQ-014 SHALL have port redirect_pc  input  32  redirect target.

Function
REQ-015 SHALL implement the states REQ, WAIT and HOLD; the state after reset SHALL be REQ.
REQ-016 In REQ: imem_req_valid=1; on imem_req_ready=1, go to WAIT.
REQ-017 In WAIT: on imem_rsp_valid=1, latch imem_rdata into instruction and go to HOLD; response latency is unbounded.
REQ-018 In HOLD: inst_valid=1; on inst_ready=1, set pc to pc+4 (modulo 2^32, wrapping 32'hFFFF_FFFC to 0) and go to REQ.
REQ-019 Minimum fetch-to-issue cost: REQ accepted in cycle n, response in n+1, inst_valid in n+2.
REQ-020 A redirect in REQ or HOLD SHALL load pc with redirect_pc, drop any held instruction, and go to REQ next cycle.
REQ-021 A redirect in HOLD in the same cycle as inst_ready SHALL take redirect_pc, not pc+4.
REQ-022 A redirect in WAIT SHALL load pc with redirect_pc and set a drop flag.
REQ-023 While the drop flag is set, the next response SHALL be discarded, the flag cleared, and the state set to REQ.
REQ-024 A redirect in WAIT in the same cycle as imem_rsp_valid SHALL discard that response and go to REQ, leaving the drop flag clear.
REQ-025 A redirect in REQ in the same cycle as imem_req_ready SHALL cancel the handshake: go to REQ with the new pc, and set the drop flag so the orphan response is discarded.
REQ-026 inst_valid SHALL be 0 outside HOLD; imem_req_valid SHALL be 0 outside REQ.
REQ-027 instruction and pc SHALL not change in HOLD except by redirect or accept.

Reset
REQ-028 With rst_n=0 at a rising edge: pc=RESET_PC, state=REQ, instruction=32'h0000_0013 (nop), drop flag=0.
REQ-029 During reset and after it: inst_valid=0; imem_req_valid is asserted from the first cycle after rst_n goes to 1.
REQ-030 Reset mid-WAIT SHALL abandon the fetch; a response arriving in the first cycle after reset SHALL be ignored because the state is REQ.

Configuration
REQ-031 Macro IFU_MISALIGN_CHECK_EN defined: a redirect_pc with bits [1:0]!=0 SHALL be loaded with bits [1:0] forced to 0, and SHALL pulse output misalign_err (1 bit) for one cycle.
REQ-032 Macro IFU_MISALIGN_CHECK_EN undefined: the misalign_err port SHALL be absent, and redirect_pc SHALL be loaded unmodified.

Structure
REQ-033 Shared package npc_pkg SHALL hold RESET_PC_DEFAULT, NOP_INST=32'h0000_0013, INST_W=32 and the fetch state enum (REQ/WAIT/HOLD).
REQ-034 The PC register with its next-PC mux (reset, +4, redirect) SHALL be sub-module ifu_pc_reg; the FSM and instruction buffer stay in ifu_fetch.

Verification
REQ-035 Reset release, memory always ready, 1-cycle response, inst_ready=1 -> pc sequence 0x80000000, 0x80000004, 0x80000008; inst_valid on every third cycle.
REQ-036 Hold inst_ready=0 for 5 cycles in HOLD -> instruction/pc stable; no new imem_req_valid.
REQ-037 Redirect to 0x80000100 in WAIT, late rdata 0xDEADBEEF -> data discarded; next request addr 0x80000100.
REQ-038 Redirect to 0x80000040 together with inst_ready in HOLD -> next imem_addr 0x80000040, not pc+4.
REQ-039 pc=0xFFFFFFFC accepted -> next imem_addr 0x00000000.
REQ-040 With IFU_MISALIGN_CHECK_EN, redirect 0x80000102 -> imem_addr 0x80000100; misalign_err high for exactly one cycle.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared fetch-stage definitions: widths, reset PC, NOP encoding and the fetch FSM states.
// Ports: none (package).
// Optional feature macro used by importers: IFU_MISALIGN_CHECK_EN.
package npc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handoff and redirect.
// master: the fetch unit; slave: memory/decode/branch side.
// Signals: imem_req_valid/ready, imem_addr, imem_rsp_valid, imem_rdata, inst_valid/ready,
//          instruction, pc, redirect_valid, redirect_pc, misalign_err (IFU_MISALIGN_CHECK_EN only).
interface ifu_fetch_if;
  import npc_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] instruction;
  logic [XLEN-1:0]   pc;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
`ifdef IFU_MISALIGN_CHECK_EN
  logic              misalign_err;
`endif

  modport master (
    output imem_req_valid, imem_addr, inst_valid, instruction, pc,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready, redirect_valid, redirect_pc
`ifdef IFU_MISALIGN_CHECK_EN
    , output misalign_err
`endif
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, instruction, pc,
    output imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready, redirect_valid, redirect_pc
`ifdef IFU_MISALIGN_CHECK_EN
    , input misalign_err
`endif
  );

endinterface

// File: rtl/ifu_pc_reg.sv
// Program counter with next-PC selection: reset value, redirect target, or sequential +4.
// Ports: clk, rst_n (sync, active-low), inc (advance by 4), redirect_valid/redirect_pc,
//        pc (registered), misalign_err (one-cycle pulse, IFU_MISALIGN_CHECK_EN only).
module ifu_pc_reg
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic            misalign_err,
`endif
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] target_c;

`ifdef IFU_MISALIGN_CHECK_EN
  // Misaligned targets are word-aligned rather than rejected.
  assign target_c = {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) misalign_err <= 1'b0;
    else        misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
`else
  assign target_c = redirect_pc;
`endif

  // Redirect outranks the sequential step; +4 wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n)              pc <= RESET_PC;
    else if (redirect_valid) pc <= target_c;
    else if (inc)            pc <= pc + XLEN'(4);
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one fetch at a time, buffers the returned word and hands it
// to decode; redirects cancel or discard in-flight fetches via a drop flag.
// Ports: clk, rst_n (sync, active-low), bus (ifu_fetch_if.master).
// Parameter: RESET_PC. Optional feature macro: IFU_MISALIGN_CHECK_EN (adds bus.misalign_err).
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master bus
);

  fetch_state_e      state;
  logic              drop;
  logic              req_valid_q;
  logic              inst_valid_q;
  logic [INST_W-1:0] inst_q;
  logic              pc_inc_c;

  assign pc_inc_c = (state == HOLD) && bus.inst_ready && !bus.redirect_valid;

  ifu_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .inc            (pc_inc_c),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
`ifdef IFU_MISALIGN_CHECK_EN
    .misalign_err   (bus.misalign_err),
`endif
    .pc             (bus.pc)
  );

  assign bus.imem_addr      = bus.pc;
  assign bus.imem_req_valid = req_valid_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.instruction    = inst_q;

  // Fetch FSM; valid outputs are registered alongside every state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= REQ;
      drop         <= 1'b0;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
    end else begin
      case (state)
        REQ: begin
          if (bus.redirect_valid) begin
            // A handshake cancelled by redirect still leaves an orphan response to discard.
            drop <= bus.imem_req_ready || (drop && !bus.imem_rsp_valid);
          end else begin
            drop <= drop && !bus.imem_rsp_valid;
            if (bus.imem_req_ready) begin
              state       <= WAIT;
              req_valid_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            drop <= 1'b0;
            if (bus.redirect_valid || drop) begin
              state       <= REQ;
              req_valid_q <= 1'b1;
            end else begin
              inst_q       <= bus.imem_rdata;
              state        <= HOLD;
              inst_valid_q <= 1'b1;
            end
          end else if (bus.redirect_valid) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.redirect_valid || bus.inst_ready) begin
            state        <= REQ;
            req_valid_q  <= 1'b1;
            inst_valid_q <= 1'b0;
          end
        end
        default: begin
          state        <= REQ;
          drop         <= 1'b0;
          req_valid_q  <= 1'b1;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: expected request addresses and issued instructions are
// queued up front; a monitor pops and compares on every request handshake and issue.
module tb_ifu_fetch;
  import npc_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } issue_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          n_issue = 0;
  logic        force_en = 1'b0;
  logic [31:0] force_data = 32'h0;
  logic [31:0] exp_req[$];
  issue_t      exp_issue[$];
  rsp_t        pend[$];
  int          issue_cyc[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: responds mem_lat cycles after each accepted request.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata     = pend[0].data;
        void'(pend.pop_front());
      end
    end
  end

  // Monitor: records memory requests and scores handshakes and issues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
          rsp_t r;
          r.due  = cyc + mem_lat;
          r.data = force_en ? force_data : (bus.imem_addr ^ 32'hA5A5_0000);
          force_en = 1'b0;
          pend.push_back(r);
          if (bus.redirect_valid !== 1'b1) begin
            if (exp_req.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL req_unexpected: got addr %h expected no request", bus.imem_addr);
            end else begin
              check32("req_addr", bus.imem_addr, exp_req.pop_front());
            end
          end
        end
        if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1 && bus.redirect_valid !== 1'b1) begin
          n_issue++;
          issue_cyc.push_back(cyc);
          if (exp_issue.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got pc %h inst %h expected no issue", bus.pc, bus.instruction);
          end else begin
            issue_t e;
            e = exp_issue.pop_front();
            check32("issue_pc", bus.pc, e.pc);
            check32("issue_inst", bus.instruction, e.inst);
          end
        end
        check32("valid_exclusive", 32'(bus.inst_valid & bus.imem_req_valid), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hold();
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (bus.inst_valid === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_hold: got no inst_valid expected inst_valid within 30 cycles");
    end
  endtask

  task automatic issue_one();
    wait_hold();
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic push_issue(input logic [31:0] p, input logic [31:0] i);
    issue_t e;
    e.pc   = p;
    e.inst = i;
    exp_issue.push_back(e);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    exp_req = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C,
                32'h8000_0010, 32'h8000_0100, 32'h8000_0104, 32'h8000_0040,
                32'h8000_0044, 32'hFFFF_FFFC, 32'h0000_0000, 32'h8000_0200,
                32'h8000_0204, 32'h8000_0000, 32'h8000_0004};
    push_issue(32'h8000_0000, 32'h25A5_0000);
    push_issue(32'h8000_0004, 32'h25A5_0004);
    push_issue(32'h8000_0008, 32'h25A5_0008);
    push_issue(32'h8000_000C, 32'h25A5_000C);
    push_issue(32'h8000_0100, 32'h25A5_0100);
    push_issue(32'h8000_0040, 32'h25A5_0040);
    push_issue(32'hFFFF_FFFC, 32'h5A5A_FFFC);
    push_issue(32'h0000_0000, 32'hA5A5_0000);
    push_issue(32'h8000_0200, 32'h25A5_0200);
    push_issue(32'h8000_0000, 32'h25A5_0000);
`ifdef IFU_MISALIGN_CHECK_EN
    exp_req.push_back(32'h8000_0100);
    push_issue(32'h8000_0100, 32'h25A5_0100);
`else
    exp_req.push_back(32'h8000_0102);
    push_issue(32'h8000_0102, 32'h25A5_0102);
`endif

    // Reset state
    repeat (3) step();
    check32("rst_pc", bus.pc, 32'h8000_0000);
    check32("rst_inst", bus.instruction, 32'h0000_0013);
    check32("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    check32("rst_req_valid", 32'(bus.imem_req_valid), 32'h1);
    rst_n = 1'b1;

    // Streaming fetch with 1-cycle memory and always-ready decode
    for (int i = 0; i < 40 && n_issue < 3; i++) step();
    bus.inst_ready = 1'b0;
    if (issue_cyc.size() >= 3) begin
      check32("issue_gap_1", 32'(issue_cyc[1] - issue_cyc[0]), 32'd3);
      check32("issue_gap_2", 32'(issue_cyc[2] - issue_cyc[1]), 32'd3);
    end else begin
      checks++;
      errors++;
      $display("FAIL stream_issues: got %0d issues expected 3", issue_cyc.size());
    end

    // Decode stall: held instruction stable, no new request
    wait_hold();
    for (int i = 0; i < 5; i++) begin
      check32("hold_pc", bus.pc, 32'h8000_000C);
      check32("hold_inst", bus.instruction, 32'h25A5_000C);
      check32("hold_req_valid", 32'(bus.imem_req_valid), 32'h0);
      step();
    end

    // Redirect while waiting; late 0xDEADBEEF must be discarded
    mem_lat    = 3;
    force_data = 32'hDEAD_BEEF;
    force_en   = 1'b1;
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    step();
    redirect(32'h8000_0100);
    mem_lat = 1;
    issue_one();

    // Redirect together with inst_ready wins over pc+4
    wait_hold();
    bus.inst_ready = 1'b1;
    redirect(32'h8000_0040);
    bus.inst_ready = 1'b0;
    issue_one();

    // Redirect in HOLD to the top word, then wrap to zero
    wait_hold();
    redirect(32'hFFFF_FFFC);
    issue_one();
    issue_one();

    // Redirect cancelling a REQ handshake; orphan response discarded
    redirect(32'h8000_0200);
    issue_one();

    // Reset mid-WAIT; the stale response lands in REQ and is ignored
    mem_lat = 2;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check32("rst2_pc", bus.pc, 32'h8000_0000);
    check32("rst2_inst", bus.instruction, 32'h0000_0013);
    check32("rst2_inst_valid", 32'(bus.inst_valid), 32'h0);
    check32("rst2_req_valid", 32'(bus.imem_req_valid), 32'h1);
    issue_one();
    mem_lat = 1;

    // Misaligned redirect target
    wait_hold();
    redirect(32'h8000_0102);
`ifdef IFU_MISALIGN_CHECK_EN
    check32("misalign_pulse", 32'(bus.misalign_err), 32'h1);
    step();
    check32("misalign_clear", 32'(bus.misalign_err), 32'h0);
`endif
    issue_one();
    bus.imem_req_ready = 1'b0;

    for (int i = 0; i < 20 && (exp_req.size() > 0 || exp_issue.size() > 0); i++) step();
    repeat (5) step();
    check32("req_left", 32'(exp_req.size()), 32'h0);
    check32("issue_left", 32'(exp_issue.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
